// File: rtl/pp_pkg.sv
// rtl/pp_pkg.sv - opcodes, instruction field helpers and stage-register types
package pp_pkg;

    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_ADD   = 4'd1;
    localparam logic [3:0] OP_SUB   = 4'd2;
    localparam logic [3:0] OP_LOADI = 4'd3;
    localparam logic [3:0] OP_AND   = 4'd4;
    localparam logic [3:0] OP_OR    = 4'd5;
    localparam logic [3:0] OP_XOR   = 4'd6;
    localparam logic [3:0] OP_JMP   = 4'd7;
    localparam logic [3:0] OP_BEQZ  = 4'd8;
    localparam logic [3:0] OP_HALT  = 4'd15;

    // Fields are extracted from a zero-extended 64-bit copy of the instruction
    // so one set of helpers serves every REG_AW/IMM_W combination.
    function automatic logic [3:0] f_opcode(input logic [63:0] instr, input int reg_aw, input int imm_w);
        return 4'(instr >> (2 * reg_aw + imm_w));
    endfunction

    function automatic logic [63:0] f_field_mask(input int width);
        return (64'd1 << width) - 64'd1;
    endfunction

    function automatic logic [63:0] f_rd(input logic [63:0] instr, input int reg_aw, input int imm_w);
        return (instr >> (reg_aw + imm_w)) & f_field_mask(reg_aw);
    endfunction

    function automatic logic [63:0] f_rs(input logic [63:0] instr, input int reg_aw, input int imm_w);
        return (instr >> imm_w) & f_field_mask(reg_aw);
    endfunction

    function automatic logic [63:0] f_imm(input logic [63:0] instr, input int imm_w);
        return instr & f_field_mask(imm_w);
    endfunction

    function automatic logic f_writes_reg(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_LOADI) ||
               (op == OP_AND) || (op == OP_OR)  || (op == OP_XOR);
    endfunction

    typedef struct packed {
        logic       valid;
        logic [3:0] op;
    } stage_ctl_t;

endpackage

// File: rtl/pp_regfile.sv
// rtl/pp_regfile.sv - register file with write-through read ports and debug read
module pp_regfile
    import pp_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int REG_AW = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [REG_AW-1:0] raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic [REG_AW-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_b,
    input  logic [REG_AW-1:0] dbg_raddr,
    output logic [DATA_W-1:0] dbg_rdata
);

    localparam int NUM_REGS = 2 ** REG_AW;

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];

    // Next register contents: only the addressed entry changes on a write
    always_comb begin
        regs_d = regs_q;
        if (we) begin
            regs_d[waddr] = wdata;
        end
    end

    // Register storage with asynchronous clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Pipeline read ports see a same-edge write so ID never needs a WB bypass
    assign rdata_a   = (we && (waddr == raddr_a)) ? wdata : regs_q[raddr_a];
    assign rdata_b   = (we && (waddr == raddr_b)) ? wdata : regs_q[raddr_b];
    assign dbg_rdata = regs_q[dbg_raddr];

endmodule

// File: rtl/pipeline_processor_p.sv
// rtl/pipeline_processor_p.sv - four-stage IF/ID/EX/WB processor with forwarding, branches and HALT
module pipeline_processor_p
    import pp_pkg::*;
#(
    parameter  int DATA_W  = 16,
    parameter  int REG_AW  = 2,
    parameter  int IMM_W   = 8,
    parameter  int IMEM_AW = 4,
    localparam int INSTR_W = 4 + 2 * REG_AW + IMM_W
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               run,
    input  logic               imem_we,
    input  logic [IMEM_AW-1:0] imem_addr,
    input  logic [INSTR_W-1:0] imem_wdata,
    input  logic [REG_AW-1:0]  dbg_raddr,
    output logic [DATA_W-1:0]  dbg_rdata,
    output logic [IMEM_AW-1:0] pc,
    output logic               wb_valid,
    output logic [REG_AW-1:0]  wb_rd,
    output logic [DATA_W-1:0]  wb_data,
    output logic               halted
);

    localparam int IMEM_DEPTH = 2 ** IMEM_AW;

    logic [INSTR_W-1:0] imem_q [IMEM_DEPTH];

    logic [IMEM_AW-1:0] pc_q, pc_d;
    logic               halted_q, halted_d;
    logic               ifid_valid_q, ifid_valid_d;
    logic [INSTR_W-1:0] ifid_instr_q, ifid_instr_d;
    stage_ctl_t         idex_ctl_q, idex_ctl_d;
    logic [REG_AW-1:0]  idex_rd_q, idex_rd_d;
    logic [REG_AW-1:0]  idex_rs_q, idex_rs_d;
    logic [DATA_W-1:0]  idex_a_q, idex_a_d;
    logic [DATA_W-1:0]  idex_b_q, idex_b_d;
    logic [IMM_W-1:0]   idex_imm_q, idex_imm_d;
    logic               wb_valid_q, wb_valid_d;
    logic [REG_AW-1:0]  wb_rd_q, wb_rd_d;
    logic [DATA_W-1:0]  wb_data_q, wb_data_d;

    logic [63:0]        id_word;
    logic [3:0]         id_op;
    logic [REG_AW-1:0]  id_rd, id_rs;
    logic [IMM_W-1:0]   id_imm;
    logic [DATA_W-1:0]  id_a, id_b;

    logic [DATA_W-1:0]  ex_a, ex_b, ex_result;
    logic [IMEM_AW-1:0] ex_target;
    logic               ex_taken, ex_halt, ex_writes;

    pp_regfile #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW)
    ) u_regfile (
        .clk       (clk),
        .reset_n   (reset_n),
        .we        (wb_valid_q && run),
        .waddr     (wb_rd_q),
        .wdata     (wb_data_q),
        .raddr_a   (id_rd),
        .rdata_a   (id_a),
        .raddr_b   (id_rs),
        .rdata_b   (id_b),
        .dbg_raddr (dbg_raddr),
        .dbg_rdata (dbg_rdata)
    );

    // Instruction memory write port; untouched by run and reset so programs survive both
    always_ff @(posedge clk) begin
        if (imem_we) begin
            imem_q[imem_addr] <= imem_wdata;
        end
    end

    // Decode the instruction held in IF/ID
    always_comb begin
        id_word = 64'(ifid_instr_q);
        id_op   = f_opcode(id_word, REG_AW, IMM_W);
        id_rd   = REG_AW'(f_rd(id_word, REG_AW, IMM_W));
        id_rs   = REG_AW'(f_rs(id_word, REG_AW, IMM_W));
        id_imm  = IMM_W'(f_imm(id_word, IMM_W));
    end

    // EX: forward from EX/WB, compute the ALU result and resolve control flow
    always_comb begin
        ex_a      = (wb_valid_q && (wb_rd_q == idex_rd_q)) ? wb_data_q : idex_a_q;
        ex_b      = (wb_valid_q && (wb_rd_q == idex_rs_q)) ? wb_data_q : idex_b_q;
        ex_target = IMEM_AW'(idex_imm_q);
        ex_taken  = idex_ctl_q.valid &&
                    ((idex_ctl_q.op == OP_JMP) || ((idex_ctl_q.op == OP_BEQZ) && (ex_a == '0)));
        ex_halt   = idex_ctl_q.valid && (idex_ctl_q.op == OP_HALT);
        ex_writes = idex_ctl_q.valid && f_writes_reg(idex_ctl_q.op);
        case (idex_ctl_q.op)
            OP_ADD:   ex_result = ex_a + ex_b;
            OP_SUB:   ex_result = ex_a - ex_b;
            OP_LOADI: ex_result = DATA_W'(idex_imm_q);
            OP_AND:   ex_result = ex_a & ex_b;
            OP_OR:    ex_result = ex_a | ex_b;
            OP_XOR:   ex_result = ex_a ^ ex_b;
            default:  ex_result = ex_a;
        endcase
    end

    // Pipeline advance: everything holds while run is low; flushes kill IF/ID and ID/EX
    always_comb begin
        pc_d         = pc_q;
        halted_d     = halted_q;
        ifid_valid_d = ifid_valid_q;
        ifid_instr_d = ifid_instr_q;
        idex_ctl_d   = idex_ctl_q;
        idex_rd_d    = idex_rd_q;
        idex_rs_d    = idex_rs_q;
        idex_a_d     = idex_a_q;
        idex_b_d     = idex_b_q;
        idex_imm_d   = idex_imm_q;
        wb_valid_d   = wb_valid_q;
        wb_rd_d      = wb_rd_q;
        wb_data_d    = wb_data_q;
        if (run) begin
            if (halted_q || ex_halt) begin
                pc_d = pc_q;
            end else if (ex_taken) begin
                pc_d = ex_target;
            end else begin
                pc_d = pc_q + 1'b1;
            end
            halted_d         = halted_q || ex_halt;
            ifid_valid_d     = !(halted_q || ex_halt || ex_taken);
            ifid_instr_d     = imem_q[pc_q];
            idex_ctl_d.valid = ifid_valid_q && !(ex_halt || ex_taken);
            idex_ctl_d.op    = id_op;
            idex_rd_d        = id_rd;
            idex_rs_d        = id_rs;
            idex_a_d         = id_a;
            idex_b_d         = id_b;
            idex_imm_d       = id_imm;
            wb_valid_d       = ex_writes;
            if (ex_writes) begin
                wb_rd_d   = idex_rd_q;
                wb_data_d = ex_result;
            end
        end
    end

    // Pipeline state registers with asynchronous reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q         <= '0;
            halted_q     <= 1'b0;
            ifid_valid_q <= 1'b0;
            ifid_instr_q <= '0;
            idex_ctl_q   <= '0;
            idex_rd_q    <= '0;
            idex_rs_q    <= '0;
            idex_a_q     <= '0;
            idex_b_q     <= '0;
            idex_imm_q   <= '0;
            wb_valid_q   <= 1'b0;
            wb_rd_q      <= '0;
            wb_data_q    <= '0;
        end else begin
            pc_q         <= pc_d;
            halted_q     <= halted_d;
            ifid_valid_q <= ifid_valid_d;
            ifid_instr_q <= ifid_instr_d;
            idex_ctl_q   <= idex_ctl_d;
            idex_rd_q    <= idex_rd_d;
            idex_rs_q    <= idex_rs_d;
            idex_a_q     <= idex_a_d;
            idex_b_q     <= idex_b_d;
            idex_imm_q   <= idex_imm_d;
            wb_valid_q   <= wb_valid_d;
            wb_rd_q      <= wb_rd_d;
            wb_data_q    <= wb_data_d;
        end
    end

    assign pc       = pc_q;
    assign halted   = halted_q;
    assign wb_valid = wb_valid_q;
    assign wb_rd    = wb_rd_q;
    assign wb_data  = wb_data_q;

endmodule

// File: tb/tb_pipeline_processor_p.sv
// tb/tb_pipeline_processor_p.sv - scoreboard bench for pipeline_processor_p against an ISA-level model
module tb_pipeline_processor_p;

    localparam logic [3:0] T_NOP = 4'd0, T_ADD = 4'd1, T_SUB = 4'd2, T_LOADI = 4'd3;
    localparam logic [3:0] T_AND = 4'd4, T_OR = 4'd5, T_XOR = 4'd6, T_JMP = 4'd7;
    localparam logic [3:0] T_BEQZ = 4'd8, T_HALT = 4'd15;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        run = 1'b0;
    logic        imem_we = 1'b0;
    logic [3:0]  imem_addr = '0;
    logic [15:0] imem_wdata = '0;
    logic [1:0]  dbg_raddr = '0;
    logic [15:0] dbg_rdata;
    logic [3:0]  pc;
    logic        wb_valid;
    logic [1:0]  wb_rd;
    logic [15:0] wb_data;
    logic        halted;

    always #5 clk = ~clk;

    pipeline_processor_p dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .run        (run),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .dbg_raddr  (dbg_raddr),
        .dbg_rdata  (dbg_rdata),
        .pc         (pc),
        .wb_valid   (wb_valid),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .halted     (halted)
    );

    int          compared = 0;
    int          mismatched = 0;
    int unsigned cyc = 0;
    int unsigned start_cyc = 0;
    logic [17:0] exp_q[$];
    int unsigned wb_cyc_q[$];
    logic [15:0] prog [16];
    logic [15:0] m_regs [4];
    int          m_hpc;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every retiring write (wb_valid during a running cycle) is popped and compared
    always @(negedge clk) begin
        if (reset_n && run && wb_valid) begin
            wb_cyc_q.push_back(cyc);
            compared++;
            if (exp_q.size() == 0) begin
                mismatched++;
                $display("FAIL unexpected_wb: got rd=%0d data=0x%0h, expected no write", wb_rd, wb_data);
            end else begin
                logic [17:0] e;
                e = exp_q.pop_front();
                if ({wb_rd, wb_data} !== e) begin
                    mismatched++;
                    $display("FAIL wb: got rd=%0d data=0x%0h, expected rd=%0d data=0x%0h",
                             wb_rd, wb_data, e[17:16], e[15:0]);
                end
            end
        end
    end

    function automatic logic [15:0] enc(input logic [3:0] op, input logic [1:0] rd,
                                        input logic [1:0] rs, input logic [7:0] imm);
        return {op, rd, rs, imm};
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic fill_halt();
        for (int a = 0; a < 16; a++) prog[a] = enc(T_HALT, 2'd0, 2'd0, 8'd0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        run = 1'b0;
        step(1);
        reset_n = 1'b1;
    endtask

    task automatic load_prog();
        run = 1'b0;
        for (int a = 0; a < 16; a++) begin
            imem_we = 1'b1;
            imem_addr = 4'(a);
            imem_wdata = prog[a];
            step(1);
        end
        imem_we = 1'b0;
    endtask

    // Architectural interpreter: executes the program one instruction at a time
    task automatic model();
        logic [15:0] r [4];
        logic [15:0] ins;
        logic [1:0]  rd, rs;
        logic [7:0]  imm;
        int          p, nxt;
        bit          done;
        exp_q.delete();
        for (int i = 0; i < 4; i++) r[i] = '0;
        p = 0;
        done = 0;
        m_hpc = 0;
        for (int s = 0; s < 200 && !done; s++) begin
            ins = prog[p];
            rd  = ins[11:10];
            rs  = ins[9:8];
            imm = ins[7:0];
            nxt = (p + 1) % 16;
            case (ins[15:12])
                T_ADD:   begin r[rd] = r[rd] + r[rs]; exp_q.push_back({rd, r[rd]}); end
                T_SUB:   begin r[rd] = r[rd] - r[rs]; exp_q.push_back({rd, r[rd]}); end
                T_LOADI: begin r[rd] = {8'd0, imm};   exp_q.push_back({rd, r[rd]}); end
                T_AND:   begin r[rd] = r[rd] & r[rs]; exp_q.push_back({rd, r[rd]}); end
                T_OR:    begin r[rd] = r[rd] | r[rs]; exp_q.push_back({rd, r[rd]}); end
                T_XOR:   begin r[rd] = r[rd] ^ r[rs]; exp_q.push_back({rd, r[rd]}); end
                T_JMP:   nxt = int'(imm[3:0]);
                T_BEQZ:  if (r[rd] == 16'd0) nxt = int'(imm[3:0]);
                T_HALT:  begin done = 1; m_hpc = (p + 2) % 16; end
                default: ;
            endcase
            p = nxt;
        end
        for (int i = 0; i < 4; i++) m_regs[i] = r[i];
    endtask

    task automatic start_prog();
        model();
        wb_cyc_q.delete();
        run = 1'b1;
        start_cyc = cyc;
    endtask

    task automatic check_regs(input string tag, input bit zero);
        for (int i = 0; i < 4; i++) begin
            dbg_raddr = 2'(i);
            #1;
            check($sformatf("%s_r%0d", tag, i), 32'(dbg_rdata), zero ? 32'd0 : 32'(m_regs[i]));
        end
    endtask

    // Run to HALT (optionally with random run stalls), then check the architectural end state
    task automatic finish_check(input string tag, input bit rnd);
        for (int i = 0; i < 400; i++) begin
            if (halted) break;
            if (rnd) run = ($urandom_range(0, 3) != 0);
            step(1);
        end
        run = 1'b1;
        check({tag, "_halt_reached"}, 32'(halted), 32'd1);
        check({tag, "_halt_pc"}, 32'(pc), 32'(m_hpc));
        step(20);
        check({tag, "_pc_frozen"}, 32'(pc), 32'(m_hpc));
        check({tag, "_wb_idle"}, 32'(wb_valid), 32'd0);
        check({tag, "_pending_wb"}, 32'(exp_q.size()), 32'd0);
        check_regs(tag, 1'b0);
    endtask

    task automatic gen_random();
        int sel, tgt;
        logic [1:0] rd, rs;
        logic [7:0] imm;
        for (int a = 0; a < 15; a++) begin
            sel = $urandom_range(0, 11);
            rd  = 2'($urandom_range(0, 3));
            rs  = 2'($urandom_range(0, 3));
            imm = 8'($urandom_range(0, 255));
            tgt = $urandom_range(a + 1, 15);
            case (sel)
                0:       prog[a] = enc(T_ADD, rd, rs, imm);
                1:       prog[a] = enc(T_SUB, rd, rs, imm);
                2:       prog[a] = enc(T_AND, rd, rs, imm);
                3:       prog[a] = enc(T_OR, rd, rs, imm);
                4:       prog[a] = enc(T_XOR, rd, rs, imm);
                5, 6:    prog[a] = enc(T_LOADI, rd, rs, imm);
                7:       prog[a] = enc(4'($urandom_range(9, 14)), rd, rs, imm);
                8:       prog[a] = enc(T_JMP, rd, rs, {imm[7:4], 4'(tgt)});
                9, 10:   prog[a] = enc(T_BEQZ, rd, rs, {imm[7:4], 4'(tgt)});
                default: prog[a] = enc(T_LOADI, rd, rs, 8'd0);
            endcase
        end
        prog[15] = enc(T_HALT, 2'd0, 2'd0, 8'd0);
    endtask

    initial begin
        // Reset state
        step(1);
        check("rst_pc", 32'(pc), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_wb_valid", 32'(wb_valid), 32'd0);
        check("rst_wb_rd", 32'(wb_rd), 32'd0);
        check("rst_wb_data", 32'(wb_data), 32'd0);
        check_regs("rst", 1'b1);
        reset_n = 1'b1;

        // Dependent add, no bubbles, fetch-to-wb latency of three edges
        fill_halt();
        prog[0] = enc(T_LOADI, 2'd0, 2'd0, 8'd10);
        prog[1] = enc(T_LOADI, 2'd1, 2'd0, 8'd15);
        prog[2] = enc(T_ADD, 2'd0, 2'd1, 8'd0);
        do_reset();
        load_prog();
        start_prog();
        finish_check("t1", 1'b0);
        check("t1_wb_count", 32'(wb_cyc_q.size()), 32'd3);
        if (wb_cyc_q.size() == 3) begin
            check("t1_first_latency", wb_cyc_q[0], start_cyc + 3);
            check("t1_no_bubble_a", wb_cyc_q[1], wb_cyc_q[0] + 1);
            check("t1_no_bubble_b", wb_cyc_q[2], wb_cyc_q[1] + 1);
        end

        // Wrapping subtraction then self-XOR
        fill_halt();
        prog[0] = enc(T_LOADI, 2'd0, 2'd0, 8'd3);
        prog[1] = enc(T_LOADI, 2'd1, 2'd0, 8'd5);
        prog[2] = enc(T_SUB, 2'd0, 2'd1, 8'd0);
        prog[3] = enc(T_XOR, 2'd0, 2'd0, 8'd0);
        do_reset();
        load_prog();
        start_prog();
        finish_check("t2", 1'b0);

        // BEQZ taken then not taken
        for (int k = 0; k < 2; k++) begin
            fill_halt();
            prog[0] = enc(T_LOADI, 2'd2, 2'd0, (k == 0) ? 8'd0 : 8'd4);
            prog[1] = enc(T_BEQZ, 2'd2, 2'd0, 8'd8);
            prog[2] = enc(T_LOADI, 2'd3, 2'd0, 8'd1);
            prog[3] = enc(T_LOADI, 2'd3, 2'd0, 8'd2);
            prog[8] = enc(T_LOADI, 2'd3, 2'd0, 8'd7);
            do_reset();
            load_prog();
            start_prog();
            finish_check((k == 0) ? "t3_taken" : "t3_not_taken", 1'b0);
        end

        // HALT with a younger instruction behind it
        fill_halt();
        prog[0] = enc(T_LOADI, 2'd0, 2'd0, 8'd9);
        prog[2] = enc(T_LOADI, 2'd0, 2'd0, 8'd1);
        do_reset();
        load_prog();
        start_prog();
        finish_check("t4", 1'b0);

        // Freeze for five cycles after five running edges
        fill_halt();
        prog[0] = enc(T_LOADI, 2'd0, 2'd0, 8'd1);
        prog[1] = enc(T_LOADI, 2'd1, 2'd0, 8'd3);
        prog[2] = enc(T_ADD, 2'd0, 2'd1, 8'd0);
        prog[3] = enc(T_ADD, 2'd0, 2'd0, 8'd0);
        prog[4] = enc(T_SUB, 2'd1, 2'd0, 8'd0);
        prog[5] = enc(T_XOR, 2'd1, 2'd0, 8'd0);
        prog[6] = enc(T_ADD, 2'd0, 2'd1, 8'd0);
        do_reset();
        load_prog();
        start_prog();
        step(5);
        run = 1'b0;
        step(5);
        check("t5_pc_held", 32'(pc), 32'd5);
        check("t5_wb_valid_held", 32'(wb_valid), 32'd1);
        check("t5_wb_data_held", 32'(wb_data), 32'd4);
        dbg_raddr = 2'd0;
        #1;
        check("t5_r0_held", 32'(dbg_rdata), 32'd1);
        dbg_raddr = 2'd1;
        #1;
        check("t5_r1_held", 32'(dbg_rdata), 32'd3);
        step(1);
        run = 1'b1;
        finish_check("t5", 1'b0);

        // Asynchronous reset mid-program, then re-execution from the retained imem
        do_reset();
        start_prog();
        step(5);
        #1;
        reset_n = 1'b0;
        #1;
        check("t6_pc", 32'(pc), 32'd0);
        check("t6_halted", 32'(halted), 32'd0);
        check("t6_wb_valid", 32'(wb_valid), 32'd0);
        check_regs("t6_clr", 1'b1);
        exp_q.delete();
        step(2);
        model();
        reset_n = 1'b1;
        finish_check("t6", 1'b0);

        // imem write to the word being fetched: old word executes, new word seen later
        fill_halt();
        prog[0] = enc(T_LOADI, 2'd0, 2'd0, 8'd1);
        prog[1] = enc(T_LOADI, 2'd1, 2'd0, 8'd2);
        prog[2] = enc(T_LOADI, 2'd2, 2'd0, 8'd3);
        do_reset();
        load_prog();
        start_prog();
        imem_we = 1'b1;
        imem_addr = 4'd0;
        imem_wdata = enc(T_LOADI, 2'd0, 2'd0, 8'h55);
        step(1);
        imem_we = 1'b0;
        finish_check("t7_old", 1'b0);
        prog[0] = enc(T_LOADI, 2'd0, 2'd0, 8'h55);
        do_reset();
        start_prog();
        finish_check("t7_new", 1'b0);

        // Random programs with forward-only branches and random run stalls
        for (int t = 0; t < 8; t++) begin
            gen_random();
            do_reset();
            load_prog();
            start_prog();
            finish_check($sformatf("rnd%0d", t), 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/pipeline_processor_p.md
Name: pipeline_processor_p

Overview:
Parametrised successor to the team's 4-register pipelined processor: 4-stage pipeline (IF, ID, EX, WB) with configurable data width, register count, immediate width and instruction-memory depth. Adds EX/WB operand forwarding, JMP/BEQZ control flow with flush, HALT, run/stall control, an instruction-memory write port and a debug register read port. Top-level CPU block; the bench drives it only through ports.

Parameters:
DATA_W, 16, register/ALU data width.
REG_AW, 2, register address width (NUM_REGS = 2**REG_AW).
IMM_W, 8, immediate field width; IMM_W >= IMEM_AW.
IMEM_AW, 4, instruction memory address width (depth 2**IMEM_AW).
INSTR_W (localparam), 4+2*REG_AW+IMM_W, instruction width (16 at defaults).

Ports:
clk  in  1  clock, rising edge.
reset_n  in  1  asynchronous, active-low reset.
run  in  1  1 = advance pipeline; 0 = freeze all pipeline state.
imem_we  in  1  instruction memory write strobe.
imem_addr  in  IMEM_AW  write address.
imem_wdata  in  INSTR_W  write data.
dbg_raddr  in  REG_AW  debug register select.
dbg_rdata  out  DATA_W  combinational register_file[dbg_raddr].
pc  out  IMEM_AW  current fetch PC.
wb_valid  out  1  EX/WB stage holds a register-writing instruction.
wb_rd  out  REG_AW  destination of that instruction.
wb_data  out  DATA_W  value being written.
halted  out  1  HALT has retired from EX.

Behaviour:
- Format (MSB first): opcode[4], rd[REG_AW], rs[REG_AW], imm[IMM_W].
- Opcodes: 0 NOP; 1 ADD rd=rd+rs; 2 SUB rd=rd-rs; 3 LOADI rd=zero-ext imm; 4 AND; 5 OR; 6 XOR; 7 JMP pc=imm[IMEM_AW-1:0]; 8 BEQZ if rd==0 pc=imm[IMEM_AW-1:0]; 15 HALT; others = NOP.
- Arithmetic wraps modulo 2**DATA_W; no flags.
- Reset (async, immediate): pc=0, all registers 0, all stage valid bits 0, wb_valid=0, wb_rd=0, wb_data=0, halted=0. imem contents NOT cleared.
- IF: combinational imem read at pc, latched into IF/ID at the edge; pc = pc+1 modulo depth.
- ID: register read; regfile is write-through (WB write at the same edge is visible).
- EX: ALU and branch resolution; operands forwarded from EX/WB when wb_valid and wb_rd matches, so back-to-back dependences need no stall.
- WB: regfile written at the edge ending the cycle in which wb_valid=1.
- Latency: instruction fetched at edge k is in EX/WB after edge k+2 (wb_* valid that cycle); register written at edge k+3.
- Taken JMP/BEQZ in EX: pc loads target at next edge; IF/ID and ID/EX invalidated (2-cycle penalty). Not-taken BEQZ: no penalty.
- HALT in EX: younger stages invalidated; pc frozen; halted=1 from next edge until reset. The older instruction in WB still retires.
- run=0: pc, all stage registers and regfile hold; wb_valid holds its value but no write occurs. imem writes still accepted.
- imem write to the address being fetched in the same cycle: fetch gets the old word; the new word is visible from the next cycle.
- Write to register 0 is legal (no hard-wired zero).

Decomposition:
- Package pp_pkg: opcode localparams, field-extraction functions parameterised by REG_AW/IMM_W, stage-register struct typedefs.
- Sub-module pp_regfile: NUM_REGS x DATA_W, one write port, two read ports plus debug read, write-through, async active-low clear.

Test Plan:
1. Load imem [0]=LOADI R0,10; [1]=LOADI R1,15; [2]=ADD R0,R1; run=1 -> wb_data 10,15,25 on consecutive cycles; R0=25, R1=15; no bubbles.
2. LOADI R0,3; LOADI R1,5; SUB R0,R1 -> R0=0xFFFE (DATA_W=16); XOR R0,R0 next -> 0.
3. [0]=LOADI R2,0; [1]=BEQZ R2,8; [2]=LOADI R3,1; [3]=LOADI R3,2; [8]=LOADI R3,7 -> R3=7; no wb for R3=1 or 2. Repeat with R2=4 -> R3 takes 1 then 2 (not taken).
4. [0]=LOADI R0,9; [1]=HALT; [2]=LOADI R0,1 -> R0=9, halted=1, pc constant for 20 cycles, no further wb_valid.
5. run=0 for 5 cycles mid-program -> pc and dbg_rdata unchanged; on run=1 results match an uninterrupted run.
6. Drop reset_n between edges during program -> pc, halted, wb_valid and all registers 0 before the next edge; imem intact; program re-executes from 0 after release.
